// File: rtl/ps2_command_tx_if.sv
// Command handshake between a host controller and ps2_command_tx.
interface ps2_command_tx_if;
    logic       Send_Command;
    logic [7:0] Command_Byte;
    logic       Busy;
    logic       Command_Sent;
    logic       Error_Timeout;
    logic       Error_Nack;

    modport master (
        output Send_Command,
        output Command_Byte,
        input  Busy,
        input  Command_Sent,
        input  Error_Timeout,
        input  Error_Nack
    );

    modport slave (
        input  Send_Command,
        input  Command_Byte,
        output Busy,
        output Command_Sent,
        output Error_Timeout,
        output Error_Nack
    );
endinterface

// File: rtl/ps2_command_tx.sv
// PS/2 host-to-device command transmitter with open-drain line drivers and watchdog.
// Define PS2_TX_ACK_CHECK_EN to turn a missing device acknowledge into Error_Nack.
module ps2_command_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic            Clock,
    input  logic            Reset,
    ps2_command_tx_if.slave cmd,
    inout  wire             PS2_Clock,
    inout  wire             PS2_Dat
);
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_INHIBIT = 3'd1;
    localparam logic [2:0] ST_RTS     = 3'd2;
    localparam logic [2:0] ST_SEND    = 3'd3;
    localparam logic [2:0] ST_ACK     = 3'd4;
    localparam logic [2:0] ST_RELEASE = 3'd5;

    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int WDT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

    logic [2:0]       state_r;
    logic [INH_W-1:0] inh_cnt_r;
    logic [WDT_W-1:0] wdt_r;
    logic [3:0]       bit_idx_r;
    logic [7:0]       byte_r;
    logic             parity_r;
    logic             clk_low_r;
    logic             dat_low_r;
    logic             busy_r;
    logic             sent_r;
    logic             tmo_r;
    logic             clk_meta_r, clk_sync_r, clk_prev_r;
    logic             dat_meta_r, dat_sync_r;
    logic             clk_fall_s;
    logic             wdt_active_s;
    logic             wdt_expired_s;
`ifdef PS2_TX_ACK_CHECK_EN
    logic             ack_r;
    logic             nack_r;
`endif

    // Open-drain: a 1 is always a release, never a driven high.
    assign PS2_Clock = clk_low_r ? 1'b0 : 1'bz;
    assign PS2_Dat   = dat_low_r ? 1'b0 : 1'bz;

    assign clk_fall_s    = clk_prev_r & ~clk_sync_r;
    assign wdt_active_s  = (state_r == ST_RTS) || (state_r == ST_SEND) ||
                           (state_r == ST_ACK) || (state_r == ST_RELEASE);
    assign wdt_expired_s = wdt_active_s && (wdt_r == WDT_W'(TIMEOUT_CYCLES - 1));

    assign cmd.Busy          = busy_r;
    assign cmd.Command_Sent  = sent_r;
    assign cmd.Error_Timeout = tmo_r;
`ifdef PS2_TX_ACK_CHECK_EN
    assign cmd.Error_Nack    = nack_r;
`else
    assign cmd.Error_Nack    = 1'b0;
`endif

    // Two-flop synchronizers on both lines plus previous clock for edge detection.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            clk_meta_r <= 1'b1;
            clk_sync_r <= 1'b1;
            clk_prev_r <= 1'b1;
            dat_meta_r <= 1'b1;
            dat_sync_r <= 1'b1;
        end else begin
            clk_meta_r <= PS2_Clock;
            clk_sync_r <= clk_meta_r;
            clk_prev_r <= clk_sync_r;
            dat_meta_r <= PS2_Dat;
            dat_sync_r <= dat_meta_r;
        end
    end

    // Transfer sequencer, line drivers, watchdog and status pulses.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r   <= ST_IDLE;
            inh_cnt_r <= '0;
            wdt_r     <= '0;
            bit_idx_r <= 4'd0;
            byte_r    <= 8'h00;
            parity_r  <= 1'b0;
            clk_low_r <= 1'b0;
            dat_low_r <= 1'b0;
            busy_r    <= 1'b0;
            sent_r    <= 1'b0;
            tmo_r     <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
            ack_r     <= 1'b0;
            nack_r    <= 1'b0;
`endif
        end else begin
            sent_r <= 1'b0;
            tmo_r  <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
            nack_r <= 1'b0;
`endif
            if (wdt_expired_s) begin
                state_r   <= ST_IDLE;
                clk_low_r <= 1'b0;
                dat_low_r <= 1'b0;
                busy_r    <= 1'b0;
                tmo_r     <= 1'b1;
            end else begin
                if (wdt_active_s) begin
                    wdt_r <= wdt_r + WDT_W'(1);
                end
                case (state_r)
                    ST_IDLE: begin
                        clk_low_r <= 1'b0;
                        dat_low_r <= 1'b0;
                        if (cmd.Send_Command) begin
                            byte_r    <= cmd.Command_Byte;
                            parity_r  <= odd_parity(cmd.Command_Byte);
                            inh_cnt_r <= '0;
                            clk_low_r <= 1'b1;
                            dat_low_r <= (INHIBIT_CYCLES == 1);
                            busy_r    <= 1'b1;
                            state_r   <= ST_INHIBIT;
                        end
                    end
                    ST_INHIBIT: begin
                        if (inh_cnt_r == INH_W'(INHIBIT_CYCLES - 1)) begin
                            clk_low_r <= 1'b0;
                            dat_low_r <= 1'b1;
                            wdt_r     <= '0;
                            state_r   <= ST_RTS;
                        end else begin
                            inh_cnt_r <= inh_cnt_r + INH_W'(1);
                            // Data goes low one cycle before the clock is released.
                            dat_low_r <= (inh_cnt_r == INH_W'(INHIBIT_CYCLES - 2));
                        end
                    end
                    ST_RTS: begin
                        if (clk_fall_s) begin
                            bit_idx_r <= 4'd0;
                            dat_low_r <= ~byte_r[0];
                            state_r   <= ST_SEND;
                        end
                    end
                    ST_SEND: begin
                        // bit_idx_r names the bit currently on the wire.
                        if (clk_fall_s) begin
                            bit_idx_r <= bit_idx_r + 4'd1;
                            if (bit_idx_r < 4'd7) begin
                                dat_low_r <= ~byte_r[bit_idx_r[2:0] + 3'd1];
                            end else if (bit_idx_r == 4'd7) begin
                                dat_low_r <= ~parity_r;
                            end else begin
                                dat_low_r <= 1'b0;
                                state_r   <= ST_ACK;
                            end
                        end
                    end
                    ST_ACK: begin
                        if (clk_fall_s) begin
`ifdef PS2_TX_ACK_CHECK_EN
                            ack_r   <= dat_sync_r;
`endif
                            state_r <= ST_RELEASE;
                        end
                    end
                    ST_RELEASE: begin
                        if (clk_sync_r && dat_sync_r) begin
                            busy_r  <= 1'b0;
                            state_r <= ST_IDLE;
`ifdef PS2_TX_ACK_CHECK_EN
                            if (ack_r) begin
                                nack_r <= 1'b1;
                            end else begin
                                sent_r <= 1'b1;
                            end
`else
                            sent_r  <= 1'b1;
`endif
                        end
                    end
                    default: begin
                        state_r   <= ST_IDLE;
                        clk_low_r <= 1'b0;
                        dat_low_r <= 1'b0;
                        busy_r    <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_command_tx.sv
// Directed bench for ps2_command_tx: vector table of full transfers plus timeout and reset sequences.
module tb_ps2_command_tx;
    localparam int INH = 40;
    localparam int TMO = 2000;
    localparam int HP  = 20;

    typedef struct {
        logic [7:0] cmd;
        bit         ack_high;
        bit         inject;
        logic [9:0] exp_frame;
        bit         exp_sent;
        bit         exp_nack;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;
    wire  ps2_clk_w;
    wire  ps2_dat_w;
    int   checks = 0;
    int   errors = 0;
    int   sent_cnt = 0;
    int   tmo_cnt = 0;
    int   nack_cnt = 0;
    vec_t vecs [5];

    ps2_command_tx_if ifc ();

    ps2_command_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .Clock     (clk),
        .Reset     (rst),
        .cmd       (ifc),
        .PS2_Clock (ps2_clk_w),
        .PS2_Dat   (ps2_dat_w)
    );

    assign ps2_clk_w = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat_w = dev_dat_low ? 1'b0 : 1'bz;
    pullup (ps2_clk_w);
    pullup (ps2_dat_w);

    always #5 clk = ~clk;

    // Count high samples of each status pulse; a one-cycle pulse counts once.
    always @(negedge clk) begin
        if (ifc.Command_Sent === 1'b1)  sent_cnt <= sent_cnt + 1;
        if (ifc.Error_Timeout === 1'b1) tmo_cnt  <= tmo_cnt + 1;
        if (ifc.Error_Nack === 1'b1)    nack_cnt <= nack_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue a request, measure the inhibit phase, end on the first cycle the clock is released.
    task automatic start_tx(input logic [7:0] b, input bit inject, input string tag);
        int low;
        int dlow;
        @(negedge clk);
        ifc.Send_Command = 1'b1;
        ifc.Command_Byte = b;
        @(negedge clk);
        ifc.Send_Command = 1'b0;
        ifc.Command_Byte = 8'h00;
        check({tag, " busy_after_accept"}, 32'(ifc.Busy), 32'd1);
        check({tag, " clk_low_after_accept"}, 32'(ps2_clk_w), 32'd0);
        low  = 1;
        dlow = (ps2_dat_w === 1'b0) ? 1 : 0;
        while (low < 4 * INH) begin
            if (inject && low == 10) begin
                ifc.Send_Command = 1'b1;
                ifc.Command_Byte = 8'h00;
            end else begin
                ifc.Send_Command = 1'b0;
            end
            @(negedge clk);
            if (ps2_clk_w === 1'b1) break;
            low++;
            if (ps2_dat_w === 1'b0) dlow++;
        end
        ifc.Send_Command = 1'b0;
        check({tag, " inhibit_cycles"}, 32'(low), 32'(INH));
        check({tag, " dat_low_in_inhibit"}, 32'(dlow), 32'd1);
        check({tag, " start_bit"}, 32'(ps2_dat_w), 32'd0);
    endtask

    // Device model: n_edges clock periods, sample data before each rising edge, ack on the 11th.
    task automatic device_clock(input int n_edges, input bit ack_high, output logic [9:0] frame);
        frame = 10'h000;
        repeat (5) @(negedge clk);
        for (int i = 0; i < n_edges; i++) begin
            dev_clk_low = 1'b1;
            repeat (HP) @(negedge clk);
            if (i < 10) frame[i] = ps2_dat_w;
            dev_clk_low = 1'b0;
            if (i == 9 && !ack_high) dev_dat_low = 1'b1;
            if (i == 10) dev_dat_low = 1'b0;
            repeat (HP) @(negedge clk);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int s0;
        int n0;
        int t0;
        logic [9:0] frame;
        s0 = sent_cnt;
        n0 = nack_cnt;
        t0 = tmo_cnt;
        start_tx(v.cmd, v.inject, tag);
        device_clock(11, v.ack_high, frame);
        repeat (40) @(negedge clk);
        check({tag, " frame"}, 32'(frame), 32'(v.exp_frame));
        check({tag, " sent_pulses"}, 32'(sent_cnt - s0), 32'(v.exp_sent));
        check({tag, " nack_pulses"}, 32'(nack_cnt - n0), 32'(v.exp_nack));
        check({tag, " tmo_pulses"}, 32'(tmo_cnt - t0), 32'd0);
        check({tag, " busy_done"}, 32'(ifc.Busy), 32'd0);
        check({tag, " clk_released"}, 32'(ps2_clk_w), 32'd1);
        check({tag, " dat_released"}, 32'(ps2_dat_w), 32'd1);
    endtask

    initial begin
        int s0;
        int n0;
        int t0;
        int n;
        logic [9:0] frame;
        vec_t rv;

        ifc.Send_Command = 1'b0;
        ifc.Command_Byte = 8'h00;
        // {cmd, ack_high, inject, frame {stop,parity,data}, sent, nack}
        vecs[0] = '{8'hED, 1'b0, 1'b0, 10'h3ED, 1'b1, 1'b0};
        vecs[1] = '{8'hF4, 1'b0, 1'b0, 10'h2F4, 1'b1, 1'b0};
        vecs[2] = '{8'h01, 1'b0, 1'b0, 10'h201, 1'b1, 1'b0};
        vecs[3] = '{8'hED, 1'b0, 1'b1, 10'h3ED, 1'b1, 1'b0};
`ifdef PS2_TX_ACK_CHECK_EN
        vecs[4] = '{8'h5A, 1'b1, 1'b0, 10'h35A, 1'b0, 1'b1};
`else
        vecs[4] = '{8'h5A, 1'b1, 1'b0, 10'h35A, 1'b1, 1'b0};
`endif

        repeat (3) @(negedge clk);
        check("reset busy", 32'(ifc.Busy), 32'd0);
        check("reset sent", 32'(ifc.Command_Sent), 32'd0);
        check("reset tmo", 32'(ifc.Error_Timeout), 32'd0);
        check("reset nack", 32'(ifc.Error_Nack), 32'd0);
        check("reset clk_line", 32'(ps2_clk_w), 32'd1);
        check("reset dat_line", 32'(ps2_dat_w), 32'd1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle busy", 32'(ifc.Busy), 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Device never clocks: watchdog fires TMO cycles after clock release.
        s0 = sent_cnt;
        n0 = nack_cnt;
        t0 = tmo_cnt;
        start_tx(8'h12, 1'b0, "tmo");
        n = 0;
        while (n < TMO + 100) begin
            @(negedge clk);
            n++;
            if (ifc.Error_Timeout === 1'b1) break;
        end
        check("tmo latency", 32'(n), 32'(TMO));
        check("tmo busy", 32'(ifc.Busy), 32'd0);
        check("tmo clk_released", 32'(ps2_clk_w), 32'd1);
        check("tmo dat_released", 32'(ps2_dat_w), 32'd1);
        repeat (10) @(negedge clk);
        check("tmo tmo_pulses", 32'(tmo_cnt - t0), 32'd1);
        check("tmo sent_pulses", 32'(sent_cnt - s0), 32'd0);
        check("tmo nack_pulses", 32'(nack_cnt - n0), 32'd0);

        // Reset after the 4th falling edge aborts silently; next request runs in full.
        s0 = sent_cnt;
        n0 = nack_cnt;
        t0 = tmo_cnt;
        start_tx(8'h00, 1'b0, "rst");
        device_clock(4, 1'b0, frame);
        check("rst partial_bits", 32'(frame[3:0]), 32'd0);
        check("rst dat_driven", 32'(ps2_dat_w), 32'd0);
        rst = 1'b1;
        #1;
        check("rst dat_released", 32'(ps2_dat_w), 32'd1);
        check("rst clk_released", 32'(ps2_clk_w), 32'd1);
        check("rst busy", 32'(ifc.Busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("rst no_pulses", 32'((sent_cnt - s0) + (nack_cnt - n0) + (tmo_cnt - t0)), 32'd0);
        rv = '{8'hFF, 1'b0, 1'b0, 10'h3FF, 1'b1, 1'b0};
        run_vec(rv, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
